scope_ctrl_nch: RTL and testbench



---
 rtl/scope_pkg.sv | 65 ++++++
 rtl/scope_btn_tick.sv | 38 +++
 rtl/scope_ctrl_nch.sv | 200 ++++++++++++++++++++
 tb/tb_scope_ctrl_nch.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
// Shared encodings, channel command type and saturating helpers for the
// oscilloscope front-panel controller.
package scope_pkg;

    localparam logic [1:0] MODE_CURSOR = 2'b00;
    localparam logic [1:0] MODE_OFFSET = 2'b01;
    localparam logic [1:0] MODE_SCALE  = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    localparam logic [1:0] BTN_INC1 = 2'd3;
    localparam logic [1:0] BTN_DEC1 = 2'd2;
    localparam logic [1:0] BTN_INC2 = 2'd1;
    localparam logic [1:0] BTN_DEC2 = 2'd0;

    // Arithmetic is done at this width so every field fits with headroom.
    localparam int VAL_W = 16;
    typedef logic [VAL_W-1:0] val_t;

    typedef enum logic [3:0] {
        CH_NOP,
        CH_OFS_INC,
        CH_OFS_DEC,
        CH_OFS_INC_C,
        CH_OFS_DEC_C,
        CH_OFS_DEF,
        CH_SH_INC,
        CH_SH_DEC,
        CH_SH_DEF,
        CH_HOLD_TGL,
        CH_HOLD_CLR,
        CH_HOLD_SET
    } ch_op_t;

    typedef struct packed {
        ch_op_t     op;
        logic [2:0] ch;
    } ch_cmd_t;

    typedef struct packed {
        logic       vld;
        logic [1:0] idx;
    } btn_sel_t;

    function automatic val_t sat_inc(val_t value, val_t step, val_t limit);
        val_t room;
        room = (value >= limit) ? '0 : limit - value;
        return (step >= room) ? limit : value + step;
    endfunction

    // limit is the floor for a decrement
    function automatic val_t sat_dec(val_t value, val_t step, val_t limit);
        return (value <= limit + step) ? limit : value - step;
    endfunction

    function automatic btn_sel_t first_btn(logic [3:0] b);
        btn_sel_t s;
        s.vld = |b;
        s.idx = BTN_DEC2;
        if (b[BTN_INC1])      s.idx = BTN_INC1;
        else if (b[BTN_DEC1]) s.idx = BTN_DEC1;
        else if (b[BTN_INC2]) s.idx = BTN_INC2;
        return s;
    endfunction

endpackage

// File: rtl/scope_btn_tick.sv
// Action tick divider plus button synchroniser and held/edge detection
// sampled on each tick.
module scope_btn_tick #(
    parameter int TICK_DIV = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] btn_n,
    output logic       tick,
    output logic [3:0] held,
    output logic [3:0] pressed_edge
);

    logic [TICK_DIV-1:0] cnt;
    logic [1:0][3:0]     sync_pipe;
    logic [3:0]          prev;
    logic [3:0]          pressed;

    assign pressed      = ~sync_pipe[1];
    assign tick         = &cnt;
    assign held         = pressed;
    assign pressed_edge = pressed & ~prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt       <= '0;
            sync_pipe <= '1;
            prev      <= '0;
        end else begin
            cnt       <= cnt + 1'b1;
            sync_pipe <= {sync_pipe[0], btn_n};
            // prev advances on every tick regardless of mode, so a mode
            // switch with a button already down never looks like a new press
            if (tick) prev <= pressed;
        end
    end

endmodule

// File: rtl/scope_ctrl_nch.sv
// N-channel oscilloscope front-panel controller: saturating cursors plus
// per-channel offset, shift and hold driven by four push buttons.
module scope_ctrl_nch #(
    parameter int NUM_CH    = 4,
    parameter int CUR_W     = 11,
    parameter int SHIFT_W   = 4,
    parameter int TICK_DIV  = 20,
    parameter int X_MAX     = 639,
    parameter int Y_MAX     = 479,
    parameter int X1_DEF    = 32,
    parameter int X2_DEF    = 90,
    parameter int Y1_DEF    = 25,
    parameter int Y2_DEF    = 100,
    parameter int OFF_DEF   = 30,
    parameter int SHIFT_DEF = 0,
    parameter int COARSE    = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [1:0]                mode_sel,
    input  logic [2:0]                ch_sel,
    input  logic                      cursor_axis,
    input  logic                      cursor_pair,
    input  logic [3:0]                btn_n,
    input  logic [1:0]                cur_en_sw,
    input  logic [NUM_CH-1:0]         ch_en_sw,
    output logic [CUR_W-1:0]          cursor_x1,
    output logic [CUR_W-1:0]          cursor_x2,
    output logic [CUR_W-1:0]          cursor_y1,
    output logic [CUR_W-1:0]          cursor_y2,
    output logic                      cursor_x_en,
    output logic                      cursor_y_en,
    output logic [NUM_CH*CUR_W-1:0]   ch_offset,
    output logic [NUM_CH*SHIFT_W-1:0] ch_shift,
    output logic [NUM_CH-1:0]         ch_en,
    output logic [NUM_CH-1:0]         ch_hold,
    output logic                      tick
);
    import scope_pkg::*;

    localparam val_t ZERO    = '0;
    localparam val_t ONE     = val_t'(1);
    localparam val_t STEP_C  = val_t'(COARSE);
    localparam val_t LIM_X   = val_t'(X_MAX);
    localparam val_t LIM_Y   = val_t'(Y_MAX);
    localparam val_t LIM_SH  = val_t'((1 << SHIFT_W) - 1);

    logic [3:0] held;
    logic [3:0] pressed_edge;
    btn_sel_t   hsel;
    btn_sel_t   esel;
    logic       ch_valid;
    ch_cmd_t    cmd;

    scope_btn_tick #(.TICK_DIV(TICK_DIV)) u_btn_tick (
        .clock        (clock),
        .reset        (reset),
        .btn_n        (btn_n),
        .tick         (tick),
        .held         (held),
        .pressed_edge (pressed_edge)
    );

    assign hsel     = first_btn(held);
    assign esel     = first_btn(pressed_edge);
    assign ch_valid = int'(ch_sel) < NUM_CH;

    // ---------------- cursors ----------------
    val_t c1, c2, lim, c1_nxt, c2_nxt;

    always_comb begin
        c1     = cursor_axis ? val_t'(cursor_y1) : val_t'(cursor_x1);
        c2     = cursor_axis ? val_t'(cursor_y2) : val_t'(cursor_x2);
        lim    = cursor_axis ? LIM_Y : LIM_X;
        c1_nxt = c1;
        c2_nxt = c2;
        if (hsel.vld && cursor_pair) begin
            // paired moves are all-or-nothing so the spacing never changes
            if (hsel.idx == BTN_INC1) begin
                if (c1 < lim && c2 < lim) begin
                    c1_nxt = c1 + ONE;
                    c2_nxt = c2 + ONE;
                end
            end else if (hsel.idx == BTN_DEC1) begin
                if (c1 != ZERO && c2 != ZERO) begin
                    c1_nxt = c1 - ONE;
                    c2_nxt = c2 - ONE;
                end
            end
        end else if (hsel.vld) begin
            case (hsel.idx)
                BTN_INC1: c1_nxt = sat_inc(c1, ONE, lim);
                BTN_DEC1: c1_nxt = sat_dec(c1, ONE, ZERO);
                BTN_INC2: c2_nxt = sat_inc(c2, ONE, lim);
                default:  c2_nxt = sat_dec(c2, ONE, ZERO);
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cursor_x1   <= CUR_W'(X1_DEF);
            cursor_x2   <= CUR_W'(X2_DEF);
            cursor_y1   <= CUR_W'(Y1_DEF);
            cursor_y2   <= CUR_W'(Y2_DEF);
            cursor_x_en <= 1'b0;
            cursor_y_en <= 1'b0;
            ch_en       <= '0;
        end else if (tick) begin
            cursor_x_en <= cur_en_sw[0];
            cursor_y_en <= cur_en_sw[1];
            ch_en       <= ch_en_sw;
            if (mode_sel == MODE_CURSOR) begin
                if (cursor_axis) begin
                    cursor_y1 <= CUR_W'(c1_nxt);
                    cursor_y2 <= CUR_W'(c2_nxt);
                end else begin
                    cursor_x1 <= CUR_W'(c1_nxt);
                    cursor_x2 <= CUR_W'(c2_nxt);
                end
            end
        end
    end

    // ---------------- channel command decode ----------------
    always_comb begin
        cmd.op = CH_NOP;
        cmd.ch = ch_sel;
        case (mode_sel)
            MODE_OFFSET: if (hsel.vld) begin
                case (hsel.idx)
                    BTN_INC1: cmd.op = CH_OFS_INC;
                    BTN_DEC1: cmd.op = CH_OFS_DEC;
                    BTN_INC2: cmd.op = CH_OFS_INC_C;
                    default:  cmd.op = CH_OFS_DEC_C;
                endcase
            end
            MODE_SCALE: if (esel.vld) begin
                case (esel.idx)
                    BTN_INC1: cmd.op = CH_SH_INC;
                    BTN_DEC1: cmd.op = CH_SH_DEC;
                    BTN_INC2: cmd.op = CH_SH_DEF;
                    default:  cmd.op = CH_OFS_DEF;
                endcase
            end
            MODE_HOLD: if (esel.vld) begin
                case (esel.idx)
                    BTN_INC1: cmd.op = CH_HOLD_TGL;
                    BTN_DEC1: cmd.op = CH_HOLD_CLR;
                    BTN_INC2: cmd.op = CH_HOLD_SET;
                    default:  cmd.op = CH_NOP;
                endcase
            end
            default: cmd.op = CH_NOP;
        endcase
        if (!ch_valid) cmd.op = CH_NOP;
    end

    // ---------------- per-channel state ----------------
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [CUR_W-1:0]   ofs;
        logic [SHIFT_W-1:0] sh;
        logic               hold;
        logic               hit;
        val_t               ofs_v;
        val_t               sh_v;

        assign hit   = (cmd.ch == 3'(k));
        assign ofs_v = val_t'(ofs);
        assign sh_v  = val_t'(sh);

        always_ff @(posedge clock) begin
            if (reset) begin
                ofs  <= CUR_W'(OFF_DEF);
                sh   <= SHIFT_W'(SHIFT_DEF);
                hold <= 1'b0;
            end else if (tick) begin
                case (cmd.op)
                    CH_OFS_INC:   if (hit) ofs <= CUR_W'(sat_inc(ofs_v, ONE, LIM_Y));
                    CH_OFS_DEC:   if (hit) ofs <= CUR_W'(sat_dec(ofs_v, ONE, ZERO));
                    CH_OFS_INC_C: if (hit) ofs <= CUR_W'(sat_inc(ofs_v, STEP_C, LIM_Y));
                    CH_OFS_DEC_C: if (hit) ofs <= CUR_W'(sat_dec(ofs_v, STEP_C, ZERO));
                    CH_OFS_DEF:   if (hit) ofs <= CUR_W'(OFF_DEF);
                    CH_SH_INC:    if (hit) sh <= SHIFT_W'(sat_inc(sh_v, ONE, LIM_SH));
                    CH_SH_DEC:    if (hit) sh <= SHIFT_W'(sat_dec(sh_v, ONE, ZERO));
                    CH_SH_DEF:    if (hit) sh <= SHIFT_W'(SHIFT_DEF);
                    CH_HOLD_TGL:  if (hit) hold <= ~hold;
                    CH_HOLD_CLR:  hold <= 1'b0;
                    CH_HOLD_SET:  hold <= 1'b1;
                    default: ;
                endcase
            end
        end

        assign ch_offset[k*CUR_W +: CUR_W]   = ofs;
        assign ch_shift[k*SHIFT_W +: SHIFT_W] = sh;
        assign ch_hold[k]                     = hold;
    end

endmodule

// File: tb/tb_scope_ctrl_nch.sv
// Directed bench for scope_ctrl_nch with a 16-cycle action tick.
module tb_scope_ctrl_nch;
    localparam int NUM_CH  = 4;
    localparam int CUR_W   = 11;
    localparam int SHIFT_W = 4;

    logic                      clock = 1'b0;
    logic                      reset = 1'b1;
    logic [1:0]                mode_sel = 2'b00;
    logic [2:0]                ch_sel = 3'd0;
    logic                      cursor_axis = 1'b0;
    logic                      cursor_pair = 1'b0;
    logic [3:0]                btn_n = 4'hF;
    logic [1:0]                cur_en_sw = 2'b00;
    logic [NUM_CH-1:0]         ch_en_sw = '0;
    logic [CUR_W-1:0]          cursor_x1, cursor_x2, cursor_y1, cursor_y2;
    logic                      cursor_x_en, cursor_y_en;
    logic [NUM_CH*CUR_W-1:0]   ch_offset;
    logic [NUM_CH*SHIFT_W-1:0] ch_shift;
    logic [NUM_CH-1:0]         ch_en, ch_hold;
    logic                      tick;

    int pass_cnt  = 0;
    int total_cnt = 0;

    scope_ctrl_nch #(.NUM_CH(NUM_CH), .CUR_W(CUR_W), .SHIFT_W(SHIFT_W), .TICK_DIV(4)) dut (
        .clock(clock), .reset(reset), .mode_sel(mode_sel), .ch_sel(ch_sel),
        .cursor_axis(cursor_axis), .cursor_pair(cursor_pair), .btn_n(btn_n),
        .cur_en_sw(cur_en_sw), .ch_en_sw(ch_en_sw),
        .cursor_x1(cursor_x1), .cursor_x2(cursor_x2), .cursor_y1(cursor_y1), .cursor_y2(cursor_y2),
        .cursor_x_en(cursor_x_en), .cursor_y_en(cursor_y_en),
        .ch_offset(ch_offset), .ch_shift(ch_shift), .ch_en(ch_en), .ch_hold(ch_hold), .tick(tick)
    );

    always #5 clock = ~clock;

    function automatic logic [CUR_W-1:0] ofs_of(int k);
        return ch_offset[k*CUR_W +: CUR_W];
    endfunction

    function automatic logic [SHIFT_W-1:0] shift_of(int k);
        return ch_shift[k*SHIFT_W +: SHIFT_W];
    endfunction

    // Returns just after the edge that applied the tick's action.
    task automatic wait_tick();
        int n = 0;
        while (n < 40) begin
            @(negedge clock);
            if (tick === 1'b1) break;
            n++;
        end
        if (n >= 40) begin
            total_cnt++;
            $display("FAIL tick_timeout: tick absent for 40 cycles, required one");
        end
        @(posedge clock);
        #1;
    endtask

    task automatic press_release(logic [3:0] b);
        btn_n = b;
        wait_tick();
        btn_n = 4'hF;
        wait_tick();
    endtask

    task automatic test_reset();
        int first = 0;
        @(posedge clock);
        #1 reset = 1'b1;
        btn_n = 4'hF;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        total_cnt++; if (cursor_x1 !== 11'd32) $display("FAIL rst_x1: got %0d want 32", cursor_x1); else pass_cnt++;
        total_cnt++; if (cursor_x2 !== 11'd90) $display("FAIL rst_x2: got %0d want 90", cursor_x2); else pass_cnt++;
        total_cnt++; if (cursor_y1 !== 11'd25) $display("FAIL rst_y1: got %0d want 25", cursor_y1); else pass_cnt++;
        total_cnt++; if (cursor_y2 !== 11'd100) $display("FAIL rst_y2: got %0d want 100", cursor_y2); else pass_cnt++;
        for (int k = 0; k < NUM_CH; k++) begin
            total_cnt++; if (ofs_of(k) !== 11'd30) $display("FAIL rst_ofs%0d: got %0d want 30", k, ofs_of(k)); else pass_cnt++;
            total_cnt++; if (shift_of(k) !== 4'd0) $display("FAIL rst_shift%0d: got %0d want 0", k, shift_of(k)); else pass_cnt++;
        end
        total_cnt++; if (ch_hold !== 4'b0000) $display("FAIL rst_hold: got %b want 0000", ch_hold); else pass_cnt++;
        total_cnt++; if (ch_en !== 4'b0000) $display("FAIL rst_ch_en: got %b want 0000", ch_en); else pass_cnt++;
        total_cnt++; if ({cursor_y_en, cursor_x_en} !== 2'b00) $display("FAIL rst_cur_en: got %b want 00", {cursor_y_en, cursor_x_en}); else pass_cnt++;
        total_cnt++; if (tick !== 1'b0) $display("FAIL rst_tick: got %b want 0", tick); else pass_cnt++;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            if (tick === 1'b1 && first == 0) first = n;
        end
        total_cnt++; if (first != 16) $display("FAIL first_tick: got cycle %0d want 16", first); else pass_cnt++;
    endtask

    task automatic test_enables();
        ch_en_sw  = 4'b1010;
        cur_en_sw = 2'b01;
        wait_tick();
        total_cnt++; if (ch_en !== 4'b1010) $display("FAIL ch_en_load: got %b want 1010", ch_en); else pass_cnt++;
        total_cnt++; if ({cursor_y_en, cursor_x_en} !== 2'b01) $display("FAIL cur_en_load: got %b want 01", {cursor_y_en, cursor_x_en}); else pass_cnt++;
    endtask

    task automatic test_cursor_x();
        mode_sel = 2'b00; cursor_axis = 1'b0; cursor_pair = 1'b0;
        btn_n = 4'b0111;
        repeat (5) wait_tick();
        btn_n = 4'hF;
        total_cnt++; if (cursor_x1 !== 11'd37) $display("FAIL cur_x1_inc: got %0d want 37", cursor_x1); else pass_cnt++;
        total_cnt++; if (cursor_x2 !== 11'd90) $display("FAIL cur_x2_hold: got %0d want 90", cursor_x2); else pass_cnt++;
        wait_tick();
    endtask

    task automatic test_offset();
        int exp_ofs[5] = '{22, 14, 6, 0, 0};
        mode_sel = 2'b01; ch_sel = 3'd2;
        btn_n = 4'b1110;
        for (int i = 0; i < 5; i++) begin
            wait_tick();
            total_cnt++;
            if (ofs_of(2) !== 11'(exp_ofs[i])) $display("FAIL ofs2_step%0d: got %0d want %0d", i, ofs_of(2), exp_ofs[i]);
            else pass_cnt++;
        end
        btn_n = 4'hF;
        total_cnt++; if (ofs_of(0) !== 11'd30) $display("FAIL ofs0_other: got %0d want 30", ofs_of(0)); else pass_cnt++;
        total_cnt++; if (ofs_of(1) !== 11'd30) $display("FAIL ofs1_other: got %0d want 30", ofs_of(1)); else pass_cnt++;
        total_cnt++; if (ofs_of(3) !== 11'd30) $display("FAIL ofs3_other: got %0d want 30", ofs_of(3)); else pass_cnt++;
        wait_tick();
    endtask

    task automatic test_scale();
        mode_sel = 2'b10; ch_sel = 3'd1;
        btn_n = 4'b0111;
        repeat (10) wait_tick();
        btn_n = 4'hF;
        total_cnt++; if (shift_of(1) !== 4'd1) $display("FAIL shift1_edge: got %0d want 1", shift_of(1)); else pass_cnt++;
        total_cnt++; if (shift_of(0) !== 4'd0) $display("FAIL shift0_other: got %0d want 0", shift_of(0)); else pass_cnt++;
        wait_tick();
        repeat (20) press_release(4'b0111);
        total_cnt++; if (shift_of(1) !== 4'd15) $display("FAIL shift1_sat: got %0d want 15", shift_of(1)); else pass_cnt++;
        press_release(4'b1101);
        total_cnt++; if (shift_of(1) !== 4'd0) $display("FAIL shift1_def: got %0d want 0", shift_of(1)); else pass_cnt++;
        ch_sel = 3'd2;
        press_release(4'b1110);
        total_cnt++; if (ofs_of(2) !== 11'd30) $display("FAIL ofs2_def: got %0d want 30", ofs_of(2)); else pass_cnt++;
    endtask

    task automatic test_hold();
        mode_sel = 2'b11; ch_sel = 3'd3;
        press_release(4'b0111);
        total_cnt++; if (ch_hold !== 4'b1000) $display("FAIL hold_tgl: got %b want 1000", ch_hold); else pass_cnt++;
        press_release(4'b1101);
        total_cnt++; if (ch_hold !== 4'b1111) $display("FAIL hold_set: got %b want 1111", ch_hold); else pass_cnt++;
        press_release(4'b1011);
        total_cnt++; if (ch_hold !== 4'b0000) $display("FAIL hold_clr: got %b want 0000", ch_hold); else pass_cnt++;
        ch_sel = 3'd5;
        press_release(4'b0111);
        total_cnt++; if (ch_hold !== 4'b0000) $display("FAIL hold_bad_ch: got %b want 0000", ch_hold); else pass_cnt++;
    endtask

    task automatic test_mode_change();
        mode_sel = 2'b01; ch_sel = 3'd5;
        btn_n = 4'b0111;
        wait_tick();
        total_cnt++; if (ofs_of(3) !== 11'd30) $display("FAIL ofs_bad_ch: got %0d want 30", ofs_of(3)); else pass_cnt++;
        mode_sel = 2'b11; ch_sel = 3'd3;
        wait_tick();
        total_cnt++; if (ch_hold !== 4'b0000) $display("FAIL mode_chg_no_edge: got %b want 0000", ch_hold); else pass_cnt++;
        btn_n = 4'hF;
        wait_tick();
        press_release(4'b0111);
        total_cnt++; if (ch_hold !== 4'b1000) $display("FAIL mode_chg_repress: got %b want 1000", ch_hold); else pass_cnt++;
    endtask

    task automatic test_pair_y();
        mode_sel = 2'b00; cursor_axis = 1'b1; cursor_pair = 1'b1;
        btn_n = 4'b0111;
        repeat (390) wait_tick();
        total_cnt++; if (cursor_y2 !== 11'd479) $display("FAIL pair_y2_top: got %0d want 479", cursor_y2); else pass_cnt++;
        total_cnt++; if (cursor_y1 !== 11'd404) $display("FAIL pair_y1_top: got %0d want 404", cursor_y1); else pass_cnt++;
        cursor_pair = 1'b0;
        repeat (66) wait_tick();
        total_cnt++; if (cursor_y1 !== 11'd470) $display("FAIL y1_470: got %0d want 470", cursor_y1); else pass_cnt++;
        cursor_pair = 1'b1;
        repeat (3) wait_tick();
        total_cnt++; if (cursor_y1 !== 11'd470) $display("FAIL pair_block_y1: got %0d want 470", cursor_y1); else pass_cnt++;
        total_cnt++; if (cursor_y2 !== 11'd479) $display("FAIL pair_block_y2: got %0d want 479", cursor_y2); else pass_cnt++;
        btn_n = 4'b1011;
        repeat (3) wait_tick();
        btn_n = 4'hF;
        total_cnt++; if (cursor_y1 !== 11'd467) $display("FAIL pair_dn_y1: got %0d want 467", cursor_y1); else pass_cnt++;
        total_cnt++; if (cursor_y2 !== 11'd476) $display("FAIL pair_dn_y2: got %0d want 476", cursor_y2); else pass_cnt++;
        total_cnt++; if (cursor_x1 !== 11'd37) $display("FAIL pair_x1_kept: got %0d want 37", cursor_x1); else pass_cnt++;
        wait_tick();
    endtask

    task automatic test_reset_mid();
        mode_sel = 2'b11; ch_sel = 3'd0;
        press_release(4'b1101);
        total_cnt++; if (ch_hold !== 4'b1111) $display("FAIL pre_rst_hold: got %b want 1111", ch_hold); else pass_cnt++;
        test_reset();
    endtask

    initial begin
        test_reset();
        test_enables();
        test_cursor_x();
        test_offset();
        test_scale();
        test_hold();
        test_mode_change();
        test_pair_y();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
